// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide sequencer: op classes,
// core op encodings, FSM states and default latencies.
package md_pkg;

  localparam int unsigned MD_MUL_LAT = 5;
  localparam int unsigned MD_DIV_LAT = 10;
  localparam int unsigned MD_CNT_W   = 4;
  localparam int unsigned HL_OP_W    = 4;
  localparam int unsigned CORE_OP_W  = 2;

  // HI/LO op classes as decoded in E; 9..15 behave as HL_NONE
  localparam logic [HL_OP_W-1:0] HL_NONE  = 4'd0;
  localparam logic [HL_OP_W-1:0] HL_MULT  = 4'd1;
  localparam logic [HL_OP_W-1:0] HL_MULTU = 4'd2;
  localparam logic [HL_OP_W-1:0] HL_DIV   = 4'd3;
  localparam logic [HL_OP_W-1:0] HL_DIVU  = 4'd4;
  localparam logic [HL_OP_W-1:0] HL_MFHI  = 4'd5;
  localparam logic [HL_OP_W-1:0] HL_MFLO  = 4'd6;
  localparam logic [HL_OP_W-1:0] HL_MTHI  = 4'd7;
  localparam logic [HL_OP_W-1:0] HL_MTLO  = 4'd8;

  localparam logic [CORE_OP_W-1:0] CORE_MULT  = 2'd0;
  localparam logic [CORE_OP_W-1:0] CORE_MULTU = 2'd1;
  localparam logic [CORE_OP_W-1:0] CORE_DIV   = 2'd2;
  localparam logic [CORE_OP_W-1:0] CORE_DIVU  = 2'd3;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_HI   = 2'd1;
  localparam logic [1:0] RD_LO   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sched_if.sv
// E-stage / D-stage / core-facing signal bundle of the multiply-divide sequencer.
interface md_sched_if #(
  parameter int unsigned CNT_W = md_pkg::MD_CNT_W
);
  logic             e_valid;
  logic [3:0]       e_op;
  logic             d_is_md;
  logic             core_start;
  logic [1:0]       core_op;
  logic             commit;
  logic             we_hi;
  logic             we_lo;
  logic [1:0]       rd_sel;
  logic             busy;
  logic             stall_d;
  logic [CNT_W-1:0] remain;

  // master: pipeline/core side; slave: the sequencer
  modport master (
    output e_valid, e_op, d_is_md,
    input  core_start, core_op, commit, we_hi, we_lo, rd_sel, busy, stall_d, remain
  );

  modport slave (
    input  e_valid, e_op, d_is_md,
    output core_start, core_op, commit, we_hi, we_lo, rd_sel, busy, stall_d, remain
  );
endinterface

// File: rtl/md_lat_counter.sv
// Loadable down-counter; zero_c flags that the value after this cycle's update is 0.
module md_lat_counter #(
  parameter int unsigned CNT_W = md_pkg::MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins over decrement; decrement saturates at 0
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_c = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply-divide sequencer: issues core ops, times the fixed latency,
// commits into HI/LO and stalls D while the unit is occupied.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MD_MUL_LAT,
  parameter int unsigned DIV_LAT = MD_DIV_LAT,
  parameter int unsigned CNT_W   = MD_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
  localparam logic [CNT_W-1:0] MUL_REM0 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_REM0 = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q;
  md_state_e        state_d;
  logic             idle;
  logic             is_arith;
  logic             is_div;
  logic             issue;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Issue decode; ops arriving while not idle are ignored
  always_comb begin
    idle         = (state_q == ST_IDLE);
    is_arith     = (md.e_op >= HL_MULT) && (md.e_op <= HL_DIVU);
    is_div       = (md.e_op == HL_DIV) || (md.e_op == HL_DIVU);
    issue        = !reset && md.e_valid && is_arith && idle;
    cnt_dec      = (state_q == ST_RUN);
    cnt_load_val = is_div ? DIV_LOAD : MUL_LOAD;
  end

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero_c   (cnt_zero)
  );

  // Next state and decoded outputs; everything is held at 0 during reset
  always_comb begin
    state_d       = state_q;
    md.core_start = 1'b0;
    md.core_op    = CORE_MULT;
    md.commit     = 1'b0;
    md.we_hi      = 1'b0;
    md.we_lo      = 1'b0;
    md.rd_sel     = RD_NONE;
    md.busy       = 1'b0;
    md.stall_d    = 1'b0;
    md.remain     = '0;

    unique case (state_q)
      ST_IDLE:   if (issue) state_d = cnt_zero ? ST_COMMIT : ST_RUN;
      ST_RUN:    if (cnt_zero) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (!reset) begin
      md.core_start = issue;
      if (issue) begin
        case (md.e_op)
          HL_MULT:  md.core_op = CORE_MULT;
          HL_MULTU: md.core_op = CORE_MULTU;
          HL_DIV:   md.core_op = CORE_DIV;
          HL_DIVU:  md.core_op = CORE_DIVU;
          default:  md.core_op = CORE_MULT;
        endcase
        md.remain = is_div ? DIV_REM0 : MUL_REM0;
      end else if (state_q == ST_RUN) begin
        md.remain = cnt_val;
      end

      md.commit  = (state_q == ST_COMMIT);
      md.we_hi   = md.e_valid && idle && (md.e_op == HL_MTHI);
      md.we_lo   = md.e_valid && idle && (md.e_op == HL_MTLO);
      if (md.e_valid && idle && (md.e_op == HL_MFHI)) md.rd_sel = RD_HI;
      if (md.e_valid && idle && (md.e_op == HL_MFLO)) md.rd_sel = RD_LO;
      md.busy    = issue || !idle;
      md.stall_d = md.d_is_md && (issue || !idle);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
